// File: rtl/inst_fmt_pkg.sv
// Shared instruction-format definitions: type codes, opcodes, field
// positions and immediate range, used by the encoder and its packer.
package inst_fmt_pkg;

    typedef enum logic [1:0] {
        TYPE_R   = 2'b00,
        TYPE_I   = 2'b01,
        TYPE_JI  = 2'b10,
        TYPE_JII = 2'b11
    } inst_type_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    localparam logic signed [31:0] IMM_MIN = -32'sd65536;
    localparam logic signed [31:0] IMM_MAX = 32'sd65535;

    // Map an opcode onto its instruction format; anything not listed is I type.
    function automatic inst_type_t classify(input logic [4:0] op);
        if (op == OP_ADD)
            return TYPE_R;
        else if (op == OP_J || op == OP_JAL || op == OP_BEX || op == OP_SETX)
            return TYPE_JI;
        else if (op == OP_JR)
            return TYPE_JII;
        else
            return TYPE_I;
    endfunction

endpackage

// File: rtl/inst_packer.sv
// Combinational classify + pack + overflow detect for one field bundle.
module inst_packer
    import inst_fmt_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  aluop,
    input  logic [31:0] imm,
    input  logic [31:0] target,
    output logic [31:0] word,
    output logic [1:0]  type_code,
    output logic        overflow
);

    inst_type_t itype;

    // Place the fields the format uses; fields that do not fit are truncated
    // into their slot and flagged.
    always_comb begin
        itype     = classify(op);
        type_code = itype;
        word      = '0;
        overflow  = 1'b0;
        word[OP_LSB +: 5] = op;
        unique case (itype)
            TYPE_R: begin
                word[RD_LSB +: 5]    = rd;
                word[RS_LSB +: 5]    = rs;
                word[RT_LSB +: 5]    = rt;
                word[SHAMT_LSB +: 5] = shamt;
                word[ALUOP_LSB +: 5] = aluop;
            end
            TYPE_I: begin
                word[RD_LSB +: 5] = rd;
                word[RS_LSB +: 5] = rs;
                word[16:0]        = imm[16:0];
                overflow = ($signed(imm) < IMM_MIN) || ($signed(imm) > IMM_MAX);
            end
            TYPE_JI: begin
                word[26:0] = target[26:0];
                overflow   = |target[31:27];
            end
            TYPE_JII: begin
                word[RD_LSB +: 5] = rd;
            end
        endcase
    end

endmodule

// File: rtl/inst_word_encoder.sv
// Session FSM that accepts field bundles, encodes them and writes the words
// sequentially into instruction memory one cycle after acceptance.
module inst_word_encoder
    import inst_fmt_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4096
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        aluop,
    input  logic [31:0]       imm,
    input  logic [31:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [1:0]        mem_type,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic [1:0]        type_code;
    logic              overflow;
    logic              accept;

    inst_packer u_packer (
        .op        (op),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .aluop     (aluop),
        .imm       (imm),
        .target    (target),
        .word      (word),
        .type_code (type_code),
        .overflow  (overflow)
    );

    // A start pulse takes priority over a beat offered in the same cycle.
    assign in_ready = (state == ST_RUN) && !start;
    assign accept   = in_valid && in_ready;

    // Session FSM, write pointer, counters and the registered IMEM write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= BASE_PTR;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_type <= '0;
            wr_count <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr <= ptr;
                mem_data <= word;
                mem_type <= type_code;
            end
            if (start) begin
                state    <= ST_RUN;
                ptr      <= BASE_PTR;
                wr_count <= '0;
                full     <= 1'b0;
                err      <= 1'b0;
                err_addr <= '0;
            end else if (accept) begin
                ptr      <= ptr + PTR_ONE;
                wr_count <= wr_count + CNT_ONE;
                if (overflow) begin
                    err <= 1'b1;
                    if (!err)
                        err_addr <= ptr;
                end
                if (wr_count + CNT_ONE == DEPTH_CNT) begin
                    state <= ST_FULL;
                    full  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_word_encoder.sv
// Self-checking bench for inst_word_encoder: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_inst_word_encoder;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 8;

    logic              clock;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op, rd, rs, rt, shamt, aluop;
    logic [31:0]       imm, target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [1:0]        mem_type;
    logic [ADDR_W:0]   wr_count;
    logic              full;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    int assertions = 0;
    int failures   = 0;

    inst_word_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs       (rs),
        .rt       (rt),
        .shamt    (shamt),
        .aluop    (aluop),
        .imm      (imm),
        .target   (target),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_type (mem_type),
        .wr_count (wr_count),
        .full     (full),
        .err      (err),
        .err_addr (err_addr)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence never reaches its end.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and return #1 after the edge that samples them.
    task automatic applyStimulus(input bit st, input bit v, input logic [4:0] o, input logic [4:0] r_d,
                                 input logic [4:0] r_s, input logic [4:0] r_t, input logic [4:0] sh,
                                 input logic [4:0] al, input logic [31:0] im, input logic [31:0] tg);
        start = st; in_valid = v; op = o; rd = r_d; rs = r_s; rt = r_t;
        shamt = sh; aluop = al; imm = im; target = tg;
        @(posedge clock);
        #1;
    endtask

    // Reference encoding from the format rules, using plain arithmetic.
    function automatic logic [31:0] model_word(input logic [4:0] o, input logic [4:0] r_d, input logic [4:0] r_s,
                                               input logic [4:0] r_t, input logic [4:0] sh, input logic [4:0] al,
                                               input logic [31:0] im, input logic [31:0] tg,
                                               output logic [1:0] ty, output bit ovf);
        longint unsigned w;
        longint unsigned uo = o, urd = r_d, urs = r_s;
        int simm = im;
        longint unsigned uimm = im;
        longint unsigned utg = tg;
        w = uo * 134217728;
        ovf = 0;
        if (o == 0) begin
            ty = 2'd0;
            w += urd * 4194304 + urs * 131072 + longint'(r_t) * 4096 + longint'(sh) * 128 + longint'(al) * 4;
        end else if (o == 1 || o == 3 || o == 22 || o == 21) begin
            ty = 2'd2;
            w += utg % 134217728;
            ovf = (utg >= 134217728);
        end else if (o == 4) begin
            ty = 2'd3;
            w += urd * 4194304;
        end else begin
            ty = 2'd1;
            w += urd * 4194304 + urs * 131072 + (uimm % 131072);
            ovf = (simm < -65536) || (simm > 65535);
        end
        return w[31:0];
    endfunction

    // Behavioural model state.
    bit              m_on = 0;
    bit              m_run, m_full, m_err, m_we;
    int              m_count;
    logic [ADDR_W-1:0] m_err_addr, m_addr;
    logic [31:0]     m_data;
    logic [1:0]      m_type;

    // Advance the model on each rising edge from the inputs the DUT sees.
    always @(posedge clock) begin
        bit acc, ovf;
        logic [1:0] ty;
        logic [31:0] w;
        m_on = 1;
        if (reset) begin
            m_run = 0; m_full = 0; m_err = 0; m_we = 0; m_count = 0;
            m_err_addr = '0; m_addr = '0; m_data = '0; m_type = '0;
        end else begin
            acc  = in_valid && m_run && !start;
            m_we = acc;
            w = model_word(op, rd, rs, rt, shamt, aluop, imm, target, ty, ovf);
            if (acc) begin
                m_addr = ADDR_W'(BASE_ADDR + m_count);
                m_data = w;
                m_type = ty;
            end
            if (start) begin
                m_run = 1; m_full = 0; m_count = 0; m_err = 0; m_err_addr = '0;
            end else if (acc) begin
                if (ovf) begin
                    if (!m_err) m_err_addr = m_addr;
                    m_err = 1;
                end
                m_count++;
                if (m_count == DEPTH) begin
                    m_run = 0; m_full = 1;
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clock) begin
        if (m_on) begin
            checkOutput("cmp_mem_we",   64'(mem_we),   64'(m_we));
            checkOutput("cmp_in_ready", 64'(in_ready), 64'(m_run && !start));
            checkOutput("cmp_wr_count", 64'(wr_count), 64'(m_count));
            checkOutput("cmp_full",     64'(full),     64'(m_full));
            checkOutput("cmp_err",      64'(err),      64'(m_err));
            checkOutput("cmp_err_addr", 64'(err_addr), 64'(m_err_addr));
            if (m_we) begin
                checkOutput("cmp_mem_addr", 64'(mem_addr), 64'(m_addr));
                checkOutput("cmp_mem_data", 64'(mem_data), 64'(m_data));
                checkOutput("cmp_mem_type", 64'(mem_type), 64'(m_type));
            end
        end
    end

    initial begin
        int sel, mode;
        logic [4:0] ro;
        logic [31:0] rimm, rtg;
        logic [4:0] op_pool [7];
        op_pool = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd21, 5'd22, 5'd5};

        reset = 1; start = 0; in_valid = 0; op = 0; rd = 0; rs = 0; rt = 0;
        shamt = 0; aluop = 0; imm = 0; target = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("rst_mem_we",   64'(mem_we),   64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_data", 64'(mem_data), 64'd0);
        checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_err",      64'(err),      64'd0);
        reset = 0;

        // First R-type word after start.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 0, 0);
        checkOutput("r_we",   64'(mem_we),   64'd1);
        checkOutput("r_addr", 64'(mem_addr), 64'd0);
        checkOutput("r_data", 64'(mem_data), 64'h00443000);
        checkOutput("r_type", 64'(mem_type), 64'd0);

        // Back-to-back I then JI in a fresh session.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 32'hFFFFFFFF, 0);
        checkOutput("i_addr", 64'(mem_addr), 64'd0);
        checkOutput("i_data", 64'(mem_data), 64'h2941FFFF);
        checkOutput("i_type", 64'(mem_type), 64'd1);
        applyStimulus(0, 1, 5'd1, 0, 0, 0, 0, 0, 0, 32'd100);
        checkOutput("ji_we",    64'(mem_we),   64'd1);
        checkOutput("ji_addr",  64'(mem_addr), 64'd1);
        checkOutput("ji_data",  64'(mem_data), 64'h08000064);
        checkOutput("ji_type",  64'(mem_type), 64'd2);
        checkOutput("ji_count", 64'(wr_count), 64'd2);

        // JII word.
        applyStimulus(0, 1, 5'd4, 5'd31, 0, 0, 0, 0, 0, 0);
        checkOutput("jii_data", 64'(mem_data), 64'h27C00000);
        checkOutput("jii_type", 64'(mem_type), 64'd3);

        // Immediate overflow at address 3, then a JI overflow at 5.
        applyStimulus(0, 1, 5'd5, 0, 0, 0, 0, 0, 32'd70000, 0);
        checkOutput("ovf_addr",     64'(mem_addr), 64'd3);
        checkOutput("ovf_data",     64'(mem_data), 64'h28011170);
        checkOutput("ovf_err",      64'(err),      64'd1);
        checkOutput("ovf_err_addr", 64'(err_addr), 64'd3);
        applyStimulus(0, 1, 5'd0, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 0, 0);
        applyStimulus(0, 1, 5'd3, 0, 0, 0, 0, 0, 0, 32'h08000001);
        checkOutput("ovf2_addr",     64'(mem_addr), 64'd5);
        checkOutput("ovf2_data",     64'(mem_data), 64'h18000001);
        checkOutput("ovf2_err_addr", 64'(err_addr), 64'd3);

        // Fill the session: only addresses 6 and 7 are still writable.
        applyStimulus(0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("last_addr",  64'(mem_addr), 64'(BASE_ADDR + DEPTH - 1));
        checkOutput("last_full",  64'(full),     64'd1);
        checkOutput("last_ready", 64'(in_ready), 64'd0);
        checkOutput("last_count", 64'(wr_count), 64'(DEPTH));
        applyStimulus(0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_no_we", 64'(mem_we), 64'd0);
        applyStimulus(0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_no_we2", 64'(mem_we), 64'd0);

        // Restart clears counters and flags.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("restart_count", 64'(wr_count), 64'd0);
        checkOutput("restart_full",  64'(full),     64'd0);
        checkOutput("restart_err",   64'(err),      64'd0);

        // start with in_valid: beat dropped.
        applyStimulus(1, 1, 5'd0, 5'd1, 0, 0, 0, 0, 0, 0);
        checkOutput("startwin_we", 64'(mem_we), 64'd0);

        // start while a write is pending: write completes, counters restart.
        applyStimulus(0, 1, 5'd0, 5'd2, 0, 0, 0, 0, 0, 0);
        checkOutput("pend_we",   64'(mem_we),   64'd1);
        checkOutput("pend_addr", 64'(mem_addr), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend_count", 64'(wr_count), 64'd0);

        // reset together with an offered beat: nothing written, back to IDLE.
        reset = 1;
        applyStimulus(0, 1, 5'd0, 5'd3, 0, 0, 0, 0, 0, 0);
        checkOutput("rstmid_we",    64'(mem_we),   64'd0);
        checkOutput("rstmid_ready", 64'(in_ready), 64'd0);
        reset = 0;
        applyStimulus(0, 1, 5'd0, 5'd3, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_no_we", 64'(mem_we), 64'd0);

        // Randomized traffic, checked by the model.
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 7);
            ro = (sel == 7) ? 5'($urandom) : op_pool[sel];
            mode = $urandom_range(0, 3);
            case (mode)
                0: rimm = $urandom_range(0, 131071) - 65536;
                1: begin
                    sel = $urandom_range(0, 3);
                    rimm = (sel == 0) ? 32'hFFFF0000 : (sel == 1) ? 32'd65535 :
                           (sel == 2) ? 32'hFFFEFFFF : 32'd65536;
                end
                default: rimm = $urandom;
            endcase
            rtg = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 134217727) : $urandom;
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7, ro,
                          5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm, rtg);
        end
        reset = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
